accel_cmd_issuer: RTL

ACCEL_CMD_ISSUER -- requirements
Module: accel_cmd_issuer

---
 rtl/accel_cmd_issuer_if.sv | 31 +++
 rtl/accel_cmd_issuer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/accel_cmd_issuer_if.sv
// Host/accelerator signal bundle for the layer command issuer.
// The issuer takes the slave side; the host/accelerator model takes the master side.
interface accel_cmd_issuer_if;
    logic        start;
    logic [15:0] in_addr;
    logic [15:0] weight_addr;
    logic [15:0] out_addr;
    logic [15:0] num_in;
    logic [15:0] num_out;
    logic        add_done;
    logic        neuron_done;
    logic        Enable;
    logic [15:0] databus;
    logic        busrdwr;
    logic        DVAL;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, in_addr, weight_addr, out_addr, num_in, num_out,
        output add_done, neuron_done,
        input  Enable, databus, busrdwr, DVAL, busy, done, err
    );

    modport slave (
        input  start, in_addr, weight_addr, out_addr, num_in, num_out,
        input  add_done, neuron_done,
        output Enable, databus, busrdwr, DVAL, busy, done, err
    );
endinterface

// File: rtl/accel_cmd_issuer.sv
// Issues one layer to the MAC accelerator: enable pulse, five descriptor words,
// then one DVAL per chunk, with a watchdog guarding every accelerator handshake.
module accel_cmd_issuer #(
    parameter int PE_SIZE = 16,
    parameter int TIMEOUT = 1023
) (
    input logic               clk,
    input logic               rst,
    accel_cmd_issuer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, CHECK, ENABLE, SEND, ARM, WAIT_ADD, FINISH, ERROR
    } state_t;

    localparam int              PE_SHIFT = $clog2(PE_SIZE);
    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [15:0]     PE_MASK  = 16'(PE_SIZE - 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    state_t          state_q;
    logic [15:0]     in_addr_q, weight_addr_q, out_addr_q, num_in_q, num_out_q;
    logic [31:0]     chunk_cnt_q;
    logic [15:0]     neuron_cnt_q;
    logic [WD_W-1:0] wdog_q;
    logic [2:0]      word_q;
    logic            enable_q, busrdwr_q, dval_q, busy_q, done_q, err_q;
    logic [15:0]     databus_q;

    logic [31:0]     total_chunks_s, chunk_cnt_d;
    logic [WD_W-1:0] wdog_d;
    logic [2:0]      word_d;
    logic            bad_desc_s;

    function automatic logic [15:0] desc_word(input logic [2:0] idx,
                                              input logic [15:0] w0, w1, w2, w3, w4);
        case (idx)
            3'd0:    desc_word = w0;
            3'd1:    desc_word = w1;
            3'd2:    desc_word = w2;
            3'd3:    desc_word = w3;
            3'd4:    desc_word = w4;
            default: desc_word = 16'h0000;
        endcase
    endfunction

    assign total_chunks_s = {16'h0000, num_in_q >> PE_SHIFT} * {16'h0000, num_out_q};
    assign chunk_cnt_d    = chunk_cnt_q + 32'd1;
    assign wdog_d         = wdog_q + WD_W'(1);
    assign word_d         = word_q + 3'd1;
    assign bad_desc_s     = (num_in_q == 16'h0000) || (num_out_q == 16'h0000) ||
                            ((num_in_q & PE_MASK) != 16'h0000);

    // Layer sequencer; pulse outputs default low so they can never overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            in_addr_q     <= 16'h0000;
            weight_addr_q <= 16'h0000;
            out_addr_q    <= 16'h0000;
            num_in_q      <= 16'h0000;
            num_out_q     <= 16'h0000;
            chunk_cnt_q   <= 32'd0;
            neuron_cnt_q  <= 16'd0;
            wdog_q        <= '0;
            word_q        <= 3'd0;
            enable_q      <= 1'b0;
            busrdwr_q     <= 1'b0;
            dval_q        <= 1'b0;
            databus_q     <= 16'h0000;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            enable_q  <= 1'b0;
            busrdwr_q <= 1'b0;
            dval_q    <= 1'b0;
            databus_q <= 16'h0000;
            if ((state_q != IDLE) && bus.neuron_done) begin
                neuron_cnt_q <= neuron_cnt_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        in_addr_q     <= bus.in_addr;
                        weight_addr_q <= bus.weight_addr;
                        out_addr_q    <= bus.out_addr;
                        num_in_q      <= bus.num_in;
                        num_out_q     <= bus.num_out;
                        chunk_cnt_q   <= 32'd0;
                        neuron_cnt_q  <= 16'd0;
                        wdog_q        <= '0;
                        word_q        <= 3'd0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        err_q         <= 1'b0;
                        state_q       <= CHECK;
                    end
                end
                CHECK: begin
                    if (bad_desc_s) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ERROR;
                    end else begin
                        enable_q <= 1'b1;
                        state_q  <= ENABLE;
                    end
                end
                ENABLE: begin
                    busrdwr_q <= 1'b1;
                    databus_q <= in_addr_q;
                    word_q    <= 3'd0;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (word_q == 3'd4) begin
                        dval_q  <= 1'b1;
                        wdog_q  <= '0;
                        state_q <= ARM;
                    end else begin
                        word_q    <= word_d;
                        busrdwr_q <= 1'b1;
                        databus_q <= desc_word(word_d, in_addr_q, weight_addr_q,
                                               out_addr_q, num_in_q, num_out_q);
                    end
                end
                // The watchdog counts cycles since the DVAL pulse, so ARM counts too.
                ARM: begin
                    wdog_q  <= wdog_d;
                    state_q <= WAIT_ADD;
                end
                WAIT_ADD: begin
                    if (bus.add_done) begin
                        chunk_cnt_q <= chunk_cnt_d;
                        wdog_q      <= '0;
                        if (chunk_cnt_d == total_chunks_s) begin
                            state_q <= FINISH;
                        end else begin
                            dval_q  <= 1'b1;
                            state_q <= ARM;
                        end
                    end else if (wdog_d >= WD_LIMIT) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ERROR;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                FINISH: begin
                    if (neuron_cnt_q == num_out_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (bus.neuron_done) begin
                        wdog_q <= '0;
                    end else if (wdog_d >= WD_LIMIT) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ERROR;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end
                ERROR: begin
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Enable  = enable_q;
    assign bus.databus = databus_q;
    assign bus.busrdwr = busrdwr_q;
    assign bus.DVAL    = dval_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule
